// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: the pass-through instruction
// fields held per entry and a resolved-operand record used by the tag snoop.
package alu_rs_pkg;

    localparam int OP_W     = 7;
    localparam int FUNCT3_W = 3;
    localparam int DATA_W   = 32;

    // Fields that travel from issue to dispatch untouched.
    typedef struct packed {
        logic [OP_W-1:0]     opcode;
        logic [FUNCT3_W-1:0] funct3;
        logic                funct7;
        logic [DATA_W-1:0]   imm;
        logic [DATA_W-1:0]   pc;
    } rs_inst_t;

    typedef struct packed {
        logic              has_dep;
        logic [DATA_W-1:0] val;
    } operand_t;

endpackage

// File: rtl/alu_rs_first_one.sv
// Lowest-set-bit priority encoder: returns the index of the lowest asserted
// request bit and a flag saying whether any bit was set.
module rs_first_one #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // NOTE: every output gets a default before the loop, so no path leaves it
    // unassigned and no latch is inferred; comb logic uses blocking '='.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued instructions until both operands are
// woken by the ALU/LSB broadcasts, then dispatches the lowest ready entry.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE   = 16,
    parameter int RS_IDX_W  = 4,
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,

    input  logic                 issue_en,
    input  logic [OP_W-1:0]      issue_opcode,
    input  logic [FUNCT3_W-1:0]  issue_funct3,
    input  logic                 issue_funct7,
    input  logic [DATA_W-1:0]    issue_val1,
    input  logic [DATA_W-1:0]    issue_val2,
    input  logic                 issue_has_dep1,
    input  logic                 issue_has_dep2,
    input  logic [ROB_POS_W-1:0] issue_dep1,
    input  logic [ROB_POS_W-1:0] issue_dep2,
    input  logic [DATA_W-1:0]    issue_imm,
    input  logic [DATA_W-1:0]    issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    output logic                 rs_full,

    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [DATA_W-1:0]    alu_result_val,
    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
    input  logic [DATA_W-1:0]    lsb_result_val,

    output logic                 alu_en,
    output logic [OP_W-1:0]      opcode,
    output logic [FUNCT3_W-1:0]  funct3,
    output logic                 funct7,
    output logic [DATA_W-1:0]    val1,
    output logic [DATA_W-1:0]    val2,
    output logic [DATA_W-1:0]    imm,
    output logic [DATA_W-1:0]    pc,
    output logic [ROB_POS_W-1:0] rob_pos
);

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   ent_has_dep1;
    logic [RS_SIZE-1:0]   ent_has_dep2;
    rs_inst_t             ent_inst    [RS_SIZE];
    logic [DATA_W-1:0]    ent_val1    [RS_SIZE];
    logic [DATA_W-1:0]    ent_val2    [RS_SIZE];
    logic [ROB_POS_W-1:0] ent_dep1    [RS_SIZE];
    logic [ROB_POS_W-1:0] ent_dep2    [RS_SIZE];
    logic [ROB_POS_W-1:0] ent_rob_pos [RS_SIZE];

    operand_t             woke1 [RS_SIZE];
    operand_t             woke2 [RS_SIZE];
    operand_t             ins_op1;
    operand_t             ins_op2;

    logic [RS_SIZE-1:0]   ready_vec;
    logic [RS_SIZE-1:0]   free_vec;
    logic [RS_IDX_W-1:0]  ready_idx;
    logic [RS_IDX_W-1:0]  free_idx;
    logic                 ready_found;
    logic                 free_found;
    logic [RS_IDX_W:0]    free_cnt;

    // Resolve one pending operand against this cycle's broadcasts; the ALU
    // broadcast wins if both carry the same tag.
    function automatic operand_t snoop(input logic                 has_dep,
                                       input logic [ROB_POS_W-1:0] dep,
                                       input logic [DATA_W-1:0]    val);
        operand_t r;
        r.has_dep = has_dep;
        r.val     = val;
        if (has_dep) begin
            if (alu_result && alu_result_rob_pos == dep) begin
                r.has_dep = 1'b0;
                r.val     = alu_result_val;
            end else if (lsb_result && lsb_result_rob_pos == dep) begin
                r.has_dep = 1'b0;
                r.val     = lsb_result_val;
            end
        end
        return r;
    endfunction

    always_comb begin
        ready_vec = '0;
        free_vec  = '0;
        free_cnt  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] && !ent_has_dep1[i] && !ent_has_dep2[i];
            free_vec[i]  = !busy[i];
            free_cnt     = free_cnt + (RS_IDX_W + 1)'(!busy[i]);
            woke1[i]     = snoop(ent_has_dep1[i], ent_dep1[i], ent_val1[i]);
            woke2[i]     = snoop(ent_has_dep2[i], ent_dep2[i], ent_val2[i]);
        end
        ins_op1 = snoop(issue_has_dep1, issue_dep1, issue_val1);
        ins_op2 = snoop(issue_has_dep2, issue_dep2, issue_val2);
    end

    // One free entry is kept as slack for the issue stage's registered view.
    assign rs_full = (free_cnt <= (RS_IDX_W + 1)'(1));

    rs_first_one #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_first_one #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            busy <= '0;
        end else if (rdy) begin
            if (ready_found) busy[ready_idx] <= 1'b0;
            if (issue_en && free_found) busy[free_idx] <= 1'b1;
        end
    end

    // NOTE: entry payload is deliberately left unreset; busy gates every use,
    // and keeping reset off the storage array lets it map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    ent_has_dep1[i] <= woke1[i].has_dep;
                    ent_val1[i]     <= woke1[i].val;
                    ent_has_dep2[i] <= woke2[i].has_dep;
                    ent_val2[i]     <= woke2[i].val;
                end
            end
            if (issue_en && free_found) begin
                ent_inst[free_idx]     <= '{issue_opcode, issue_funct3, issue_funct7,
                                            issue_imm, issue_pc};
                ent_has_dep1[free_idx] <= ins_op1.has_dep;
                ent_val1[free_idx]     <= ins_op1.val;
                ent_has_dep2[free_idx] <= ins_op2.has_dep;
                ent_val2[free_idx]     <= ins_op2.val;
                ent_dep1[free_idx]     <= issue_dep1;
                ent_dep2[free_idx]     <= issue_dep2;
                ent_rob_pos[free_idx]  <= issue_rob_pos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            alu_en  <= 1'b0;
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= 1'b0;
            val1    <= '0;
            val2    <= '0;
            imm     <= '0;
            pc      <= '0;
            rob_pos <= '0;
        end else if (rdy) begin
            alu_en <= ready_found;
            if (ready_found) begin
                opcode  <= ent_inst[ready_idx].opcode;
                funct3  <= ent_inst[ready_idx].funct3;
                funct7  <= ent_inst[ready_idx].funct7;
                imm     <= ent_inst[ready_idx].imm;
                pc      <= ent_inst[ready_idx].pc;
                val1    <= ent_val1[ready_idx];
                val2    <= ent_val2[ready_idx];
                rob_pos <= ent_rob_pos[ready_idx];
            end
        end
    end

    issue_when_full: assert property (@(posedge clk) disable iff (rst)
        (rdy && !rollback && issue_en) |-> free_found);

endmodule

// File: tb/tb_alu_rs.sv
// Directed testbench for alu_rs: latency, wakeup, bypass, full threshold,
// dispatch priority, broadcast conflict, rollback and rdy stall.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        issue_en;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic        issue_has_dep1, issue_has_dep2;
    logic [3:0]  issue_dep1, issue_dep2, issue_rob_pos;
    logic        rs_full;
    logic        alu_result, lsb_result;
    logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
    logic [31:0] alu_result_val, lsb_result_val;
    logic        alu_en;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] val1, val2, imm, pc;
    logic [3:0]  rob_pos;

    int tests  = 0;
    int failed = 0;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_en(issue_en), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
        .issue_funct7(issue_funct7), .issue_val1(issue_val1), .issue_val2(issue_val2),
        .issue_has_dep1(issue_has_dep1), .issue_has_dep2(issue_has_dep2),
        .issue_dep1(issue_dep1), .issue_dep2(issue_dep2), .issue_imm(issue_imm),
        .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos), .rs_full(rs_full),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
        .alu_result_val(alu_result_val), .lsb_result(lsb_result),
        .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
        .alu_en(alu_en), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_issue(input logic [6:0] op, input logic [31:0] v1, input logic hd1,
                             input logic [3:0] d1, input logic [31:0] v2, input logic hd2,
                             input logic [3:0] d2, input logic [3:0] rp);
        issue_en       = 1'b1;
        issue_opcode   = op;
        issue_funct3   = 3'b101;
        issue_funct7   = 1'b1;
        issue_val1     = v1;
        issue_has_dep1 = hd1;
        issue_dep1     = d1;
        issue_val2     = v2;
        issue_has_dep2 = hd2;
        issue_dep2     = d2;
        issue_rob_pos  = rp;
        issue_imm      = 32'h100 + 32'(rp);
        issue_pc       = 32'h1000 + {26'd0, rp, 2'b00};
    endtask

    task automatic clr();
        issue_en   = 1'b0;
        alu_result = 1'b0;
        lsb_result = 1'b0;
        rollback   = 1'b0;
    endtask

    task automatic alu_bc(input logic [3:0] tag, input logic [31:0] v);
        alu_result = 1'b1; alu_result_rob_pos = tag; alu_result_val = v;
    endtask

    task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] v);
        lsb_result = 1'b1; lsb_result_rob_pos = tag; lsb_result_val = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clr();
        issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 1'b0;
        issue_val1 = '0; issue_val2 = '0; issue_has_dep1 = 1'b0; issue_has_dep2 = 1'b0;
        issue_dep1 = '0; issue_dep2 = '0; issue_imm = '0; issue_pc = '0; issue_rob_pos = '0;
        alu_result_rob_pos = '0; alu_result_val = '0; lsb_result_rob_pos = '0; lsb_result_val = '0;
        tick(); tick();
        rst = 1'b0;
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL reset_alu_en: got %b exp 0", alu_en); end
        tests++; if (rs_full !== 1'b0) begin failed++; $display("FAIL reset_rs_full: got %b exp 0", rs_full); end
        tests++; if ({rob_pos, val1, opcode} !== '0) begin failed++; $display("FAIL reset_payload: rob_pos %h val1 %h opcode %h exp 0", rob_pos, val1, opcode); end
    endtask

    task automatic test_add();
        set_issue(7'h33, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        tick(); clr();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL add_same_cycle: alu_en %b exp 0", alu_en); end
        tick();
        tests++; if (alu_en !== 1'b1) begin failed++; $display("FAIL add_dispatch: alu_en %b exp 1", alu_en); end
        tests++; if (val1 !== 32'd5 || val2 !== 32'd7) begin failed++; $display("FAIL add_vals: %0d/%0d exp 5/7", val1, val2); end
        tests++; if (rob_pos !== 4'd3 || opcode !== 7'h33 || funct3 !== 3'b101 || funct7 !== 1'b1) begin
            failed++; $display("FAIL add_fields: rob %0d op %h f3 %b f7 %b exp 3/33/101/1", rob_pos, opcode, funct3, funct7); end
        tests++; if (imm !== 32'h103 || pc !== 32'h100c) begin failed++; $display("FAIL add_imm_pc: %h/%h exp 103/100c", imm, pc); end
        tick();
        tests++; if (alu_en !== 1'b0 || val1 !== 32'd5) begin failed++; $display("FAIL add_after: alu_en %b val1 %0d exp 0/5", alu_en, val1); end
    endtask

    task automatic test_wakeup();
        set_issue(7'h33, 32'hdead, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4);
        tick(); clr(); tick();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL wake_waiting: alu_en %b exp 0", alu_en); end
        alu_bc(4'd2, 32'h10);
        tick(); clr();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL wake_bc_cycle: alu_en %b exp 0", alu_en); end
        tick();
        tests++; if (alu_en !== 1'b1 || val1 !== 32'h10 || val2 !== 32'd1 || rob_pos !== 4'd4) begin
            failed++; $display("FAIL wake_dispatch: en %b val1 %h val2 %h rob %0d exp 1/10/1/4", alu_en, val1, val2, rob_pos); end
        tick();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL wake_once: alu_en %b exp 0", alu_en); end
    endtask

    task automatic test_bypass();
        set_issue(7'h13, 32'd1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 4'd5);
        lsb_bc(4'd6, 32'hab);
        tick(); clr(); tick();
        tests++; if (alu_en !== 1'b1 || val2 !== 32'hab || rob_pos !== 4'd5 || opcode !== 7'h13) begin
            failed++; $display("FAIL bypass: en %b val2 %h rob %0d op %h exp 1/ab/5/13", alu_en, val2, rob_pos, opcode); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 15; i++) begin
            set_issue(7'h33, 32'h0, 1'b1, (i == 0) ? 4'd7 : 4'd8, 32'(i), 1'b0, 4'd0, 4'(i));
            tick();
            if (i == 13) begin
                tests++; if (rs_full !== 1'b0) begin failed++; $display("FAIL full_two_free: rs_full %b exp 0", rs_full); end
            end
        end
        clr();
        tests++; if (rs_full !== 1'b1) begin failed++; $display("FAIL full_one_free: rs_full %b exp 1", rs_full); end
        alu_bc(4'd7, 32'h77);
        tick(); clr();
        tests++; if (rs_full !== 1'b1 || alu_en !== 1'b0) begin failed++; $display("FAIL full_wake_cycle: rs_full %b en %b exp 1/0", rs_full, alu_en); end
        tick();
        tests++; if (alu_en !== 1'b1 || rob_pos !== 4'd0 || val1 !== 32'h77) begin
            failed++; $display("FAIL full_dispatch: en %b rob %0d val1 %h exp 1/0/77", alu_en, rob_pos, val1); end
        tests++; if (rs_full !== 1'b0) begin failed++; $display("FAIL full_release: rs_full %b exp 0", rs_full); end
        rollback = 1'b1; tick(); rollback = 1'b0;
        tests++; if (alu_en !== 1'b0 || rs_full !== 1'b0) begin failed++; $display("FAIL full_flush: en %b rs_full %b exp 0/0", alu_en, rs_full); end
    endtask

    task automatic test_order();
        logic [3:0] exp_rob [3] = '{4'd14, 4'd11, 4'd6};
        for (int i = 0; i < 10; i++) begin
            set_issue(7'h33, 32'h0, 1'b1, (i == 1 || i == 4 || i == 9) ? 4'd9 : 4'd10,
                      32'd2, 1'b0, 4'd0, 4'(15 - i));
            tick();
        end
        clr();
        alu_bc(4'd9, 32'h99);
        tick(); clr();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL order_idle: alu_en %b exp 0", alu_en); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (alu_en !== 1'b1 || rob_pos !== exp_rob[k] || val1 !== 32'h99) begin
                failed++; $display("FAIL order_%0d: en %b rob %0d val1 %h exp 1/%0d/99", k, alu_en, rob_pos, val1, exp_rob[k]); end
        end
        tick();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL order_done: alu_en %b exp 0", alu_en); end
        rollback = 1'b1; tick(); rollback = 1'b0;
    endtask

    task automatic test_conflict();
        set_issue(7'h33, 32'h0, 1'b1, 4'd3, 32'h0, 1'b1, 4'd4, 4'd8);
        tick(); clr();
        alu_bc(4'd3, 32'h33);
        lsb_bc(4'd3, 32'h55);
        tick(); clr();
        lsb_bc(4'd4, 32'h44);
        tick(); clr();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL conflict_wait: alu_en %b exp 0", alu_en); end
        tick();
        tests++; if (alu_en !== 1'b1 || val1 !== 32'h33 || val2 !== 32'h44 || rob_pos !== 4'd8) begin
            failed++; $display("FAIL conflict_dispatch: en %b val1 %h val2 %h rob %0d exp 1/33/44/8", alu_en, val1, val2, rob_pos); end
        tick();
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 6; i++) begin
            set_issue(7'h33, 32'h0, 1'b1, 4'd12, 32'd3, 1'b0, 4'd0, 4'(i));
            tick();
        end
        clr();
        alu_bc(4'd12, 32'h12);
        tick(); clr();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL rb_wake_cycle: alu_en %b exp 0", alu_en); end
        tick();
        tests++; if (alu_en !== 1'b1 || rob_pos !== 4'd0) begin failed++; $display("FAIL rb_pre: en %b rob %0d exp 1/0", alu_en, rob_pos); end
        rollback = 1'b1; tick(); rollback = 1'b0;
        tests++; if (alu_en !== 1'b0 || rs_full !== 1'b0 || rob_pos !== 4'd0 || val1 !== 32'd0) begin
            failed++; $display("FAIL rb_clear: en %b full %b rob %0d val1 %h exp 0/0/0/0", alu_en, rs_full, rob_pos, val1); end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL rb_quiet_%0d: alu_en %b exp 0", k, alu_en); end
        end
    endtask

    task automatic test_rdy_hold();
        set_issue(7'h33, 32'h0, 1'b1, 4'd13, 32'h0, 1'b0, 4'd0, 4'd9);
        tick();
        set_issue(7'h33, 32'h21, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0, 4'd2);
        tick(); clr(); tick();
        tests++; if (alu_en !== 1'b1 || rob_pos !== 4'd2 || val1 !== 32'h21) begin
            failed++; $display("FAIL rdy_pre: en %b rob %0d val1 %h exp 1/2/21", alu_en, rob_pos, val1); end
        rdy = 1'b0;
        alu_bc(4'd13, 32'h99);
        set_issue(7'h33, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (alu_en !== 1'b1 || rob_pos !== 4'd2) begin
                failed++; $display("FAIL rdy_freeze_%0d: en %b rob %0d exp 1/2", k, alu_en, rob_pos); end
        end
        rdy = 1'b1; clr();
        tick();
        tests++; if (alu_en !== 1'b0 || rob_pos !== 4'd2) begin failed++; $display("FAIL rdy_resume: en %b rob %0d exp 0/2", alu_en, rob_pos); end
        alu_bc(4'd13, 32'h99);
        tick(); clr(); tick();
        tests++; if (alu_en !== 1'b1 || rob_pos !== 4'd9 || val1 !== 32'h99) begin
            failed++; $display("FAIL rdy_held_entry: en %b rob %0d val1 %h exp 1/9/99", alu_en, rob_pos, val1); end
        tick();
        tests++; if (alu_en !== 1'b0) begin failed++; $display("FAIL rdy_no_insert: alu_en %b exp 0", alu_en); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wakeup();
        test_bypass();
        test_full();
        test_order();
        test_conflict();
        test_rollback();
        test_rdy_hold();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
